// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: opcode map, default field widths
// and the retire-side classification helpers.
package tomasulo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int FUNC_W_DEF = 4;

  typedef enum logic [FUNC_W_DEF-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_MUL   = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_BEQ   = 4'b0110,
    OP_BNEQ  = 4'b0111
  } opcode_e;

  // Codes 1000-1111 fall through both helpers as no-write, no-store.
  function automatic logic is_reg_write(input logic [FUNC_W_DEF-1:0] func);
    return func <= OP_LOAD;
  endfunction

  function automatic logic is_store(input logic [FUNC_W_DEF-1:0] func);
    return func == OP_STORE;
  endfunction

endpackage

// File: rtl/tomasulo_rob.sv
// Circular reorder buffer: in-order allocate from decode, out-of-order CDB
// completion, in-order retire, and a full flush when a mispredicted branch retires.
module tomasulo_rob
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  look_tag_a,
  input  logic [TAG_W-1:0]  look_tag_b,
  output logic              look_ready_a,
  output logic              look_ready_b,
  output logic [DATA_W-1:0] look_data_a,
  output logic [DATA_W-1:0] look_data_b,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_we,
  output logic              commit_store,
  output logic              flush,
  output logic              empty,
  output logic              full
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  misp_q, misp_d;
  logic [FUNC_W-1:0] func_q [DEPTH];
  logic [FUNC_W-1:0] func_d [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [REG_W-1:0]  rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic commit_fire;
  logic alloc_fire;
  logic flush_fire;

  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign commit_valid = valid_q[head_q] && done_q[head_q];
  assign flush        = commit_valid && misp_q[head_q];
  assign alloc_ready  = !full && !flush;
  assign alloc_tag    = tail_q;

  assign commit_fire = commit_valid && commit_ready;
  assign flush_fire  = commit_fire && flush;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign commit_tag   = head_q;
  assign commit_rd    = commit_valid ? rd_q[head_q]   : '0;
  assign commit_data  = commit_valid ? data_q[head_q] : '0;
  assign commit_we    = commit_valid && is_reg_write(FUNC_W_DEF'(func_q[head_q]));
  assign commit_store = commit_valid && is_store(FUNC_W_DEF'(func_q[head_q]));

  assign look_ready_a = valid_q[look_tag_a] && done_q[look_tag_a];
  assign look_ready_b = valid_q[look_tag_b] && done_q[look_tag_b];
  assign look_data_a  = valid_q[look_tag_a] ? data_q[look_tag_a] : '0;
  assign look_data_b  = valid_q[look_tag_b] ? data_q[look_tag_b] : '0;

  always_comb begin
    // NOTE: every *_d starts from its *_q so no path through this block infers a latch.
    valid_d = valid_q;
    done_d  = done_q;
    misp_d  = misp_q;
    func_d  = func_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);

    // A result aimed at the entry retiring this edge is dropped with it.
    if (cdb_valid && valid_q[cdb_tag] && !(commit_fire && cdb_tag == head_q)) begin
      done_d[cdb_tag] = 1'b1;
      misp_d[cdb_tag] = cdb_mispredict;
      data_d[cdb_tag] = cdb_data;
    end

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + TAG_W'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      misp_d[tail_q]  = 1'b0;
      func_d[tail_q]  = alloc_func;
      rd_d[tail_q]    = alloc_rd;
      data_d[tail_q]  = '0;
      tail_d          = tail_q + TAG_W'(1);
    end

    if (flush_fire) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the statement order.
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; every reader qualifies it with the valid bit.
  always_ff @(posedge clk1) begin
    done_q <= done_d;
    misp_q <= misp_d;
    func_q <= func_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule
